hilo_muldiv: RTL and testbench

//   Owns the architectural HI/LO registers.

---
 rtl/hilo_muldiv_pkg.sv | 31 +++
 rtl/hilo_muldiv_if.sv | 14 +
 rtl/hilo_muldiv_divider.sv | 50 +++++
 rtl/hilo_muldiv.sv | 129 ++++++++++++
 tb/tb_hilo_muldiv.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared funct codes, FSM state and op-descriptor types for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} muldiv_state_t;

  typedef struct packed {
    logic isDiv;
    logic isSigned;
  } muldiv_op_t;

  function automatic logic isMulDiv(input logic [5:0] funct);
    return (funct == FN_MULT) || (funct == FN_MULTU) ||
           (funct == FN_DIV)  || (funct == FN_DIVU);
  endfunction

  // Only meaningful when isMulDiv() is true: bit1 selects divide, bit0 set means unsigned.
  function automatic muldiv_op_t decodeOp(input logic [5:0] funct);
    muldiv_op_t op;
    op.isDiv    = funct[1];
    op.isSigned = ~funct[0];
    return op;
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Execute-side issue bus of the HI/LO unit; master = Execute/hazard side, slave = hilo_muldiv.
interface hilo_muldiv_if;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, funct, a, b, kill, input busy, hi, lo);
  modport slave  (input start, funct, a, b, kill, output busy, hi, lo);
endinterface

// File: rtl/hilo_muldiv_divider.sv
// Unsigned restoring divider, one quotient bit per step; done flags the final step.
// Latency: ITERS steps after start; no backpressure, the owner decides when to step.
module muldiv_divider #(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  localparam int CW = $clog2(ITERS);

  logic [31:0]   rem;
  logic [31:0]   quo;
  logic [31:0]   dvs;
  logic [CW-1:0] cnt;
  logic [32:0]   shifted;
  logic          fits;

  // The 33-bit partial remainder: previous remainder shifted left with the next dividend bit.
  assign shifted = {rem, quo[31]};
  assign fits    = shifted >= {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      rem <= fits ? 32'(shifted - {1'b0, dvs}) : shifted[31:0];
      quo <= {quo[30:0], fits};
    end
  end

  assign done      = step && (cnt == CW'(ITERS - 1));
  assign quotient  = quo;
  assign remainder = rem;
endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO owner: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO; busy high 33 cycles per mul/div, kill aborts.
// MULDIV_FAST_MUL_EN: single-cycle multiply written at the accept edge; divide unchanged.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int ITERS = 32
) (
  input  logic         clk,
  input  logic         reset,
  hilo_muldiv_if.slave bus
);
  localparam int CW = $clog2(ITERS);

  muldiv_state_t state, stateNext;
  muldiv_op_t    op, decOp;
  logic          sa, sb;
  logic [63:0]   prod, mcand;
  logic [31:0]   mplier;
  logic [CW-1:0] cnt;
  logic          idle, issue, accMul, accDiv, goRun, lastStep;
  logic [31:0]   absA, absB;
  logic          negA, negB;
  logic          divDone;
  logic [31:0]   divQuo, divRem;
  logic [63:0]   mulFix;
  logic [31:0]   quoFix, remFix;

  assign decOp  = decodeOp(bus.funct);
  assign idle   = (state == MD_IDLE);
  assign issue  = idle && bus.start && !bus.kill;
  assign accMul = issue && isMulDiv(bus.funct) && !decOp.isDiv;
  assign accDiv = issue && isMulDiv(bus.funct) && decOp.isDiv && (bus.b != '0);

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] extA, extB, fastProd;
  assign extA     = {{32{decOp.isSigned & bus.a[31]}}, bus.a};
  assign extB     = {{32{decOp.isSigned & bus.b[31]}}, bus.b};
  assign fastProd = extA * extB;
  assign goRun    = accDiv;
`else
  assign goRun    = accMul || accDiv;
`endif

  assign negA = decOp.isSigned & bus.a[31];
  assign negB = decOp.isSigned & bus.b[31];
  assign absA = negA ? -bus.a : bus.a;
  assign absB = negB ? -bus.b : bus.b;

  assign lastStep = op.isDiv ? divDone : (cnt == CW'(ITERS - 1));

  always_comb begin
    stateNext = state;
    case (state)
      MD_IDLE: if (goRun)    stateNext = MD_RUN;
      MD_RUN:  if (lastStep) stateNext = MD_FIX;
      MD_FIX:                stateNext = MD_IDLE;
      default:               stateNext = MD_IDLE;
    endcase
    if (bus.kill) stateNext = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MD_IDLE;
      op     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state <= stateNext;
      if (goRun) begin
        op     <= decOp;
        sa     <= negA;
        sb     <= negB;
        prod   <= '0;
        mcand  <= {32'b0, absA};
        mplier <= absB;
        cnt    <= '0;
      end else if (state == MD_RUN) begin
        cnt <= cnt + 1'b1;
        if (!op.isDiv) begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
      end
    end
  end

  muldiv_divider #(.ITERS(ITERS)) uDivider (
    .clk       (clk),
    .reset     (reset),
    .start     (accDiv),
    .step      ((state == MD_RUN) && op.isDiv),
    .dividend  (absA),
    .divisor   (absB),
    .done      (divDone),
    .quotient  (divQuo),
    .remainder (divRem)
  );

  // Remainder takes the dividend's sign, matching truncating division.
  assign mulFix = (sa ^ sb) ? -prod : prod;
  assign quoFix = (sa ^ sb) ? -divQuo : divQuo;
  assign remFix = sa ? -divRem : divRem;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.hi <= '0;
      bus.lo <= '0;
    end else if (!bus.kill) begin
      if (state == MD_FIX) begin
        if (op.isDiv) {bus.hi, bus.lo} <= {remFix, quoFix};
        else          {bus.hi, bus.lo} <= mulFix;
      end else if (issue) begin
        if (bus.funct == FN_MTHI) bus.hi <= bus.a;
        if (bus.funct == FN_MTLO) bus.lo <= bus.a;
`ifdef MULDIV_FAST_MUL_EN
        if (accMul) {bus.hi, bus.lo} <= fastProd;
`endif
      end
    end
  end

  assign bus.busy = !idle;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomised + directed bench for hilo_muldiv against an arithmetic HI/LO reference model.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_muldiv_if bus();

  hilo_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic; returns expected number of busy cycles.
  task automatic modelOp(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
    longint sA, sB, q, r;
    logic [63:0] p;
    int mulCyc;
`ifdef MULDIV_FAST_MUL_EN
    mulCyc = 0;
`else
    mulCyc = 33;
`endif
    cyc = 0;
    sA  = longint'($signed(a));
    sB  = longint'($signed(b));
    case (fn)
      FN_MULT:  begin p = sA * sB; {mHi, mLo} = p; cyc = mulCyc; end
      FN_MULTU: begin p = {32'b0, a} * {32'b0, b}; {mHi, mLo} = p; cyc = mulCyc; end
      FN_DIV: if (b != 0) begin
        q = sA / sB; r = sA % sB;
        mLo = q[31:0]; mHi = r[31:0]; cyc = 33;
      end
      FN_DIVU: if (b != 0) begin mLo = a / b; mHi = a % b; cyc = 33; end
      FN_MTHI: mHi = a;
      FN_MTLO: mLo = a;
      default: ;
    endcase
  endtask

  task automatic runOp(input string tag, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b);
    int cyc, n;
    modelOp(fn, a, b, cyc);
    bus.start = 1'b1; bus.funct = fn; bus.a = a; bus.b = b;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      tick();
    end
    check({tag, " busyCycles"}, 32'(n), 32'(cyc));
    check({tag, " hi"}, bus.hi, mHi);
    check({tag, " lo"}, bus.lo, mLo);
  endtask

  // Start an op, inject a stray MTHI on busy cycle 3, kill on busy cycle killAt.
  task automatic runKill(input string tag, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input int killAt);
    int n;
    bus.start = 1'b1; bus.funct = fn; bus.a = a; bus.b = b;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      bus.kill  = (n == killAt);
      bus.start = (n == 3);
      bus.funct = FN_MTHI;
      bus.a     = 32'h0000BEEF;
      tick();
      if (n == killAt) break;
    end
    bus.kill  = 1'b0;
    bus.start = 1'b0;
    check({tag, " killCycle"}, 32'(n), 32'(killAt));
    check({tag, " busyAfterKill"}, {31'b0, bus.busy}, 32'd0);
    repeat (3) tick();
    check({tag, " busyStaysLow"}, {31'b0, bus.busy}, 32'd0);
    check({tag, " hi"}, bus.hi, mHi);
    check({tag, " lo"}, bus.lo, mLo);
  endtask

  logic [5:0] fnTab [7];

  initial begin
    fnTab = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO, 6'h2A};

    reset     = 1'b1;
    bus.start = 1'b1;
    bus.funct = FN_MTHI;
    bus.a     = 32'hDEADBEEF;
    bus.b     = 32'd0;
    bus.kill  = 1'b0;
    repeat (2) tick();
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    bus.start = 1'b0;
    reset     = 1'b0;
    tick();
    check("post-reset hi", bus.hi, 32'd0);

    runOp("mult", FN_MULT, 32'hFFFFFFFD, 32'd7);
    check("mult hi lit", bus.hi, 32'hFFFFFFFF);
    check("mult lo lit", bus.lo, 32'hFFFFFFEB);
    runOp("div", FN_DIV, 32'hFFFFFFF9, 32'd2);
    check("div lo lit", bus.lo, 32'hFFFFFFFD);
    check("div hi lit", bus.hi, 32'hFFFFFFFF);
    runOp("divu", FN_DIVU, 32'd7, 32'd2);
    check("divu lo lit", bus.lo, 32'd3);
    check("divu hi lit", bus.hi, 32'd1);
    runOp("divovf", FN_DIV, 32'h80000000, 32'hFFFFFFFF);
    check("divovf lo lit", bus.lo, 32'h80000000);
    check("divovf hi lit", bus.hi, 32'd0);
    runOp("divu0", FN_DIVU, 32'd99, 32'd0);
    runOp("div0", FN_DIV, 32'h80000000, 32'd0);
    runOp("mthi", FN_MTHI, 32'h00001234, 32'd0);
    check("mthi lit", bus.hi, 32'h00001234);
    runOp("mtlo", FN_MTLO, 32'hCAFEF00D, 32'd0);
    runOp("nop", 6'h2A, 32'h11111111, 32'h22222222);
    runOp("multu", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu hi lit", bus.hi, 32'hFFFFFFFE);
    check("multu lo lit", bus.lo, 32'd1);
    runOp("multneg", FN_MULT, 32'h80000000, 32'h80000000);

    runKill("kill10", FN_DIVU, 32'hFFFF0000, 32'd3, 10);
    runKill("killFix", FN_DIV, 32'h12345678, 32'hFFFFFF00, 33);

    // start and kill together in IDLE drop the op
    bus.start = 1'b1; bus.kill = 1'b1; bus.funct = FN_MTLO; bus.a = 32'h0BADF00D;
    tick();
    check("startKill lo", bus.lo, mLo);
    bus.funct = FN_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    tick();
    check("startKill busy", {31'b0, bus.busy}, 32'd0);
    bus.start = 1'b0; bus.kill = 1'b0;
    tick();

    for (int i = 0; i < 40; i++) begin
      logic [5:0]  fn;
      logic [31:0] ra, rb;
      fn = fnTab[$urandom_range(0, 6)];
      ra = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($signed($urandom_range(0, 20)) - 10);
        default: rb = $urandom;
      endcase
      runOp($sformatf("rnd%0d", i), fn, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
